// File: rtl/ad724_pkg.sv
// Shared constants and state encoding for the AD724 colour-subcarrier generator.
// Defaults assume the 28 MHz system clock and a 32-bit phase accumulator.
package ad724_pkg;

    localparam int unsigned SYS_CLK_HZ    = 28_000_000;
    localparam int unsigned DEF_ACC_WIDTH = 32;

    // round(f_sc / SYS_CLK_HZ * 2^32)
    localparam int unsigned DEF_INC_PAL  = 32'd680080269;
    localparam int unsigned DEF_INC_NTSC = 32'd549072454;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;

endpackage

// File: rtl/ad724_colorclk_gen_if.sv
// Control-register inputs and FSC outputs of the subcarrier generator.
// The register/bench side is master; the generator is slave.
interface ad724_colorclk_gen_if;

    logic mode;
    logic enable;
    logic fsc_out;
    logic fsc_oe;
    logic fsc_tick;
    logic mode_active;

    modport master (
        output mode,
        output enable,
        input  fsc_out,
        input  fsc_oe,
        input  fsc_tick,
        input  mode_active
    );

    modport slave (
        input  mode,
        input  enable,
        output fsc_out,
        output fsc_oe,
        output fsc_tick,
        output mode_active
    );

endinterface

// File: rtl/ad724_nco.sv
// Phase accumulator with carry-out; clr has priority over run.
// wrap is the combinational carry of the addition taken on the next edge.
module ad724_nco #(
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 run,
    input  logic [ACC_WIDTH-1:0] inc,
    output logic                 acc_msb,
    output logic                 wrap
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, inc};
    assign wrap    = run & w_sum[ACC_WIDTH];
    assign acc_msb = r_acc[ACC_WIDTH-1];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (run) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ad724_colorclk_gen.sv
// AD724 FSC generator: registers mode/enable, runs the IDLE/RUN/DRAIN FSM and
// switches the NCO increment only on accumulator wraps so fsc_out never glitches.
module ad724_colorclk_gen
    import ad724_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned INC_PAL   = DEF_INC_PAL,
    parameter int unsigned INC_NTSC  = DEF_INC_NTSC
) (
    input  logic                clk,
    input  logic                rst,
    ad724_colorclk_gen_if.slave bus
);

    localparam logic [ACC_WIDTH-1:0] L_INC_PAL  = ACC_WIDTH'(INC_PAL);
    localparam logic [ACC_WIDTH-1:0] L_INC_NTSC = ACC_WIDTH'(INC_NTSC);

    logic   r_mode_q;
    logic   r_en_q;
    state_t r_state;
    logic   r_inc_sel;
    logic   r_fsc_oe;
    logic   r_fsc_tick;

    state_t                w_state_nxt;
    logic                  w_load_sel;
    logic                  w_clr;
    logic                  w_run;
    logic                  w_wrap;
    logic                  w_acc_msb;
    logic [ACC_WIDTH-1:0]  w_inc;

    assign w_inc = r_inc_sel ? L_INC_PAL : L_INC_NTSC;

    ad724_nco #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_nco (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .run     (w_run),
        .inc     (w_inc),
        .acc_msb (w_acc_msb),
        .wrap    (w_wrap)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load_sel  = 1'b0;
        w_clr       = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (r_en_q) begin
                    w_state_nxt = RUN;
                    w_load_sel  = 1'b1;
                end
            end
            RUN: begin
                w_run      = 1'b1;
                w_load_sel = w_wrap;
                if (!r_en_q) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_run = 1'b1;
                // Re-enable wins over a coincident wrap: keep running with phase intact.
                if (r_en_q) begin
                    w_state_nxt = RUN;
                    w_load_sel  = w_wrap;
                end else if (w_wrap) begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                    w_load_sel  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q   <= 1'b0;
            r_en_q     <= 1'b0;
            r_state    <= IDLE;
            r_inc_sel  <= 1'b0;
            r_fsc_oe   <= 1'b0;
            r_fsc_tick <= 1'b0;
        end else begin
            r_mode_q   <= bus.mode;
            r_en_q     <= bus.enable;
            r_state    <= w_state_nxt;
            r_fsc_oe   <= (w_state_nxt != IDLE);
            r_fsc_tick <= w_wrap;
            if (w_load_sel) begin
                r_inc_sel <= r_mode_q;
            end
        end
    end

    // The accumulator is cleared whenever the FSM is idle, so its MSB flop is fsc_out directly.
    assign bus.fsc_out     = w_acc_msb;
    assign bus.fsc_oe      = r_fsc_oe;
    assign bus.fsc_tick    = r_fsc_tick;
    assign bus.mode_active = r_inc_sel;

endmodule

// File: tb/tb_ad724_colorclk_gen.sv
// Bench for ad724_colorclk_gen (8-bit accumulator, PAL period 4 clk, NTSC period 8 clk)
// plus a scaled wrap-count run of ad724_nco at default width.
module tb_ad724_colorclk_gen;
    import ad724_pkg::*;

    localparam int unsigned W          = 8;
    localparam int          MOD        = 1 << W;
    localparam int          NCO_CYCLES = 28000;

    typedef struct packed {
        logic fsc_out;
        logic fsc_oe;
        logic fsc_tick;
        logic mode_active;
    } obs_t;

    logic clk;
    logic rst;
    logic nco_run;
    logic nco_msb;
    logic nco_wrap;

    ad724_colorclk_gen_if bus ();

    ad724_colorclk_gen #(
        .ACC_WIDTH (W),
        .INC_PAL   (64),
        .INC_NTSC  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ad724_nco #(
        .ACC_WIDTH (32)
    ) u_nco (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .run     (nco_run),
        .inc     (32'(DEF_INC_PAL)),
        .acc_msb (nco_msb),
        .wrap    (nco_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t sb_q[$];
    obs_t cur      = '0;
    obs_t prev     = '0;
    logic oe_low_seen = 1'b0;

    // Reference model state
    int   m_state;
    int   m_acc;
    logic m_sel;
    logic m_tick;
    logic m_oe;
    logic m_mode_q;
    logic m_en_q;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_acc    = 0;
        m_sel    = 1'b0;
        m_tick   = 1'b0;
        m_oe     = 1'b0;
        m_mode_q = 1'b0;
        m_en_q   = 1'b0;
    endtask

    // Advances the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        int   inc;
        int   sum;
        int   nxt;
        logic wrap;
        inc  = m_sel ? 64 : 32;
        sum  = m_acc + inc;
        wrap = (m_state != 0) && (sum >= MOD);
        nxt  = m_state;
        if (m_state == 0) begin
            if (m_en_q) begin
                nxt   = 1;
                m_sel = m_mode_q;
            end
        end else if (m_state == 1 || m_en_q) begin
            nxt   = m_en_q ? 1 : 2;
            m_acc = sum % MOD;
            if (wrap) m_sel = m_mode_q;
        end else if (wrap) begin
            nxt   = 0;
            m_acc = 0;
            m_sel = m_mode_q;
        end else begin
            m_acc = sum % MOD;
        end
        m_state  = nxt;
        m_tick   = wrap;
        m_oe     = (nxt != 0);
        m_mode_q = bus.mode;
        m_en_q   = bus.enable;
    endtask

    task automatic cycle();
        obs_t e;
        if (!rst) begin
            model_step();
            e.fsc_out     = (m_acc >= MOD / 2);
            e.fsc_oe      = m_oe;
            e.fsc_tick    = m_tick;
            e.mode_active = m_sel;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        prev            = cur;
        cur.fsc_out     = bus.fsc_out;
        cur.fsc_oe      = bus.fsc_oe;
        cur.fsc_tick    = bus.fsc_tick;
        cur.mode_active = bus.mode_active;
        if (!cur.fsc_oe) oe_low_seen = 1'b1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("model", 32'(cur), 32'(e));
        end
    endtask

    task automatic run_until_tick(input int max_cyc, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!cur.fsc_tick && n < max_cyc);
        if (!cur.fsc_tick) check("tick_timeout", 32'(cur.fsc_tick), 32'd1);
    endtask

    task automatic wait_oe(input string tag);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!cur.fsc_oe && n < 10);
        check(tag, n, 2);
    endtask

    task automatic grab_pattern(output logic [7:0] pat);
        pat[7] = cur.fsc_out;
        for (int i = 6; i >= 0; i--) begin
            cycle();
            pat[i] = cur.fsc_out;
        end
    endtask

    task automatic check_async_zero(input string tag);
        check({tag, "_out"},  32'(bus.fsc_out),     32'd0);
        check({tag, "_oe"},   32'(bus.fsc_oe),      32'd0);
        check({tag, "_tick"}, 32'(bus.fsc_tick),    32'd0);
        check({tag, "_ma"},   32'(bus.mode_active), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gap;
        int          n;
        int          ticks;
        int          wraps;
        longint      exp_wraps;
        logic [7:0]  pat;

        rst        = 1'b1;
        nco_run    = 1'b0;
        bus.mode   = 1'b1;
        bus.enable = 1'b0;
        model_reset();
        #12;
        check_async_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle();

        // PAL start-up: latency, waveform and period
        bus.enable = 1'b1;
        wait_oe("t1_oe_latency");
        grab_pattern(pat);
        check("t1_pattern", 32'(pat), 32'h33);
        run_until_tick(10, gap);
        run_until_tick(10, gap);
        check("t1_gap_a", gap, 4);
        run_until_tick(10, gap);
        check("t1_gap_b", gap, 4);

        // Mode change mid-period: old period completes, then 8-clk periods
        cycle();
        bus.mode = 1'b0;
        run_until_tick(10, gap);
        check("t2_finish_old", gap, 3);
        check("t2_ma_before", 32'(prev.mode_active), 32'd1);
        check("t2_ma_at_wrap", 32'(cur.mode_active), 32'd0);
        grab_pattern(pat);
        check("t2_pattern", 32'(pat), 32'h0f);
        run_until_tick(10, gap);
        run_until_tick(20, gap);
        check("t2_gap", gap, 8);

        // Stop at acc=0x40: drain until wrap, one final tick
        cycle();
        cycle();
        bus.enable = 1'b0;
        run_until_tick(20, gap);
        check("t3_drain_len", gap, 6);
        check("t3_oe_before", 32'(prev.fsc_oe), 32'd1);
        check("t3_oe_after", 32'(cur.fsc_oe), 32'd0);
        check("t3_out_after", 32'(cur.fsc_out), 32'd0);
        ticks = 0;
        repeat (12) begin
            cycle();
            if (cur.fsc_tick) ticks++;
        end
        check("t3_no_more_ticks", ticks, 0);

        // Brief disable inside a period: no drop of fsc_oe, period unbroken
        bus.enable = 1'b1;
        wait_oe("t4_oe_latency");
        run_until_tick(20, gap);
        check("t4_first_gap", gap, 8);
        oe_low_seen = 1'b0;
        bus.enable  = 1'b0;
        cycle();
        cycle();
        bus.enable = 1'b1;
        run_until_tick(20, gap);
        check("t4_gap_across", gap + 2, 8);
        run_until_tick(20, gap);
        check("t4_gap_next", gap, 8);
        check("t4_oe_held", 32'(oe_low_seen), 32'd0);

        // Asynchronous reset while fsc_out is high
        bus.mode = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!cur.fsc_out && n < 20);
        check("t5_found_high", 32'(cur.fsc_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_async_zero("t5_async");
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_oe("t5_oe_latency");
        grab_pattern(pat);
        check("t5_pattern", 32'(pat), 32'h33);

        // Default-width NCO, PAL increment, scaled run length
        nco_run = 1'b1;
        wraps   = 0;
        repeat (NCO_CYCLES) begin
            if (nco_wrap) wraps++;
            @(posedge clk);
            #1;
        end
        exp_wraps = (longint'(NCO_CYCLES) * longint'(DEF_INC_PAL)) >> 32;
        check("nco_wraps", wraps, 32'(exp_wraps));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
